header_loader: RTL and testbench
================================

// Module: header_loader
// PURPOSE
//   Downstream of the UART receive path. Consumes the byte stream (rx byte + one-cycle
//   ready strobe), frames HEADER_BYTES bytes into a block header and presents it to the
//   hashing core with a valid/ack handshake. An inter-byte timeout resynchronises framing
//   after a dropped or partial transfer, so a stray byte cannot misalign every later header.
// PARAMETERS
//   HEADER_BYTES    80         bytes per header; header width = 8*HEADER_BYTES
//   TIMEOUT_CYCLES  5000000    idle clocks mid-frame before discard (100 ms @ 50 MHz)
//   CNT_W           7          width of byte_count; must hold HEADER_BYTES
// PORTS
//   clock         in   1      system clock, all logic on posedge
//   reset         in   1      asynchronous, active-high
//   rx_byte       in   8      received byte, valid while rx_valid=1
//   rx_valid      in   1      one-cycle strobe per received byte
//   header_ack    in   1      consumer accepted header_data (sampled only in HOLD)
//   header_data   out  640    assembled header; byte 0 at [639:632], last byte at [7:0]
//   header_valid  out  1      high in HOLD; header_data stable while high
//   byte_count    out  CNT_W  bytes accepted into the current frame
//   overrun       out  1      sticky: a byte arrived while in HOLD (cleared by reset only)
//   cksum_err     out  1      one-cycle pulse on checksum mismatch (0 without macro)
// BEHAVIOUR
//   - Reset: state=IDLE, header_data=0, header_valid=0, byte_count=0, overrun=0,
//     cksum_err=0, timeout counter=0, assembly register=0.
//   - States: IDLE, RECV, CHECK (macro only), HOLD.
//   - IDLE: rx_valid -> shift byte in, byte_count=1, RECV. HEADER_BYTES=1 is unsupported.
//   - RECV: each rx_valid shifts assembly reg left 8, new byte into [7:0], byte_count+1,
//     timeout counter cleared. Counter increments on every clock without rx_valid; when it
//     reaches TIMEOUT_CYCLES-1 -> discard frame, byte_count=0, IDLE (no outputs change).
//   - On the HEADER_BYTES-th byte: without macro, header_data <= assembled value and
//     header_valid=1 on the next cycle (1-cycle latency), state HOLD, byte_count=0.
//   - HOLD: header_valid=1 until header_ack sampled high; the next cycle header_valid=0,
//     state IDLE. header_data retains the last accepted header after ack until the next
//     frame completes. rx_valid in HOLD: byte dropped, overrun=1. ack and rx_valid in the
//     same cycle: byte still dropped, overrun=1, ack honoured.
//   - header_ack outside HOLD is ignored. Timeout counter does not run in IDLE or HOLD.
//   - Reset mid-frame or in HOLD: immediate return to reset values; partial frame lost.
// CONFIGURATION
//   HEADER_LOADER_CHECKSUM_EN
//   - Defined: frame is HEADER_BYTES+1 bytes; final byte = XOR of all header bytes. After
//     the HEADER_BYTES-th byte go to CHECK (still timeout-governed); on the checksum byte,
//     match -> load header_data, HOLD (header_valid 1 cycle after checksum strobe);
//     mismatch -> cksum_err pulse 1 cycle, discard, IDLE, header_data unchanged.
//   - Undefined: no CHECK state, cksum_err tied 0, frame is exactly HEADER_BYTES bytes.
// TESTING
//   - 80 bytes 0x00..0x4F, one per 10 clk -> header_valid 1 clk after last strobe,
//     header_data[639:632]=0x00, [7:0]=0x4F; ack -> header_valid 0 next clk.
//   - 30 bytes then 5000000 idle clk, then 80 bytes 0xA5 -> byte_count returns 0 on
//     timeout; single header of all 0xA5, no valid after first 30.
//   - Header held, send 1 byte before ack -> overrun=1, header_data unchanged; ack with
//     simultaneous rx_valid -> overrun stays 1, IDLE, byte_count=0.
//   - Assert reset after 40 bytes -> all outputs 0 immediately; then 80 bytes -> clean header.
//   - Macro on: 80 bytes 0x01 + cksum 0x00 -> header_valid; repeat with cksum 0x01 ->
//     cksum_err 1-clk pulse, no header_valid, header_data keeps prior header.
//   - Back-to-back rx_valid every clk for 80 bytes -> correct header, byte_count 1..79.

Source files
------------

// File: rtl/header_loader.sv
// -----------------------------------------------------------------------------
// header_loader
//   Frames the UART receive byte stream into a HEADER_BYTES-byte block header
//   and presents it to the hashing core with a valid/ack handshake. If the gap
//   between bytes inside a frame grows too long, the partial frame is dropped.
//   This keeps framing aligned after a lost or stray byte.
//
//   Optional feature macro: HEADER_LOADER_CHECKSUM_EN
//     When the macro is defined, each frame carries one extra trailing byte.
//     That byte is the XOR of all header bytes. A frame whose checksum does
//     not match is dropped, and o_cksum_err pulses for one cycle. When the
//     macro is undefined, o_cksum_err is tied low.
//
// Ports
//   i_clock         system clock, all logic on posedge
//   i_reset         asynchronous, active-high reset
//   i_rx_byte       received byte, valid while i_rx_valid=1
//   i_rx_valid      one-cycle strobe per received byte
//   i_header_ack    consumer accepted o_header_data (sampled only in HOLD)
//   o_header_data   assembled header, byte 0 in the top byte lane
//   o_header_valid  high while a header is held for the consumer
//   o_byte_count    bytes accepted into the current frame
//   o_overrun       sticky flag: a byte arrived while a header was held
//   o_cksum_err     one-cycle pulse on checksum mismatch
// -----------------------------------------------------------------------------
module header_loader #(
  parameter int HEADER_BYTES   = 80,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int CNT_W          = 7
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [7:0]                i_rx_byte,
  input  logic                      i_rx_valid,
  input  logic                      i_header_ack,
  output logic [8*HEADER_BYTES-1:0] o_header_data,
  output logic                      o_header_valid,
  output logic [CNT_W-1:0]          o_byte_count,
  output logic                      o_overrun,
  output logic                      o_cksum_err
);

  localparam int HDR_W = 8 * HEADER_BYTES;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HEADER_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_HOLD  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t             r_state, w_state_nx;
  logic [HDR_W-1:0]   r_asm,    w_asm_nx;
  logic [HDR_W-1:0]   r_header, w_header_nx;
  logic               r_valid,  w_valid_nx;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nx;
  logic [TO_W-1:0]    r_to,     w_to_nx;
  logic               r_overrun, w_overrun_nx;
  logic [HDR_W-1:0]   w_asm_shift;
  logic               w_to_expired;
`ifdef HEADER_LOADER_CHECKSUM_EN
  logic [7:0]         r_xor,    w_xor_nx;
  logic               r_cksum,  w_cksum_nx;
`endif

  // The new byte always enters the low lane, so byte 0 ends up in the top lane.
  assign w_asm_shift  = {r_asm[HDR_W-9:0], i_rx_byte};
  // This is the last idle clock that is allowed before the partial frame is dropped.
  assign w_to_expired = (r_to == TO_LAST);

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nx   = r_state;
    w_asm_nx     = r_asm;
    w_header_nx  = r_header;
    w_valid_nx   = r_valid;
    w_cnt_nx     = r_cnt;
    w_to_nx      = r_to;
    w_overrun_nx = r_overrun;
`ifdef HEADER_LOADER_CHECKSUM_EN
    w_xor_nx     = r_xor;
    w_cksum_nx   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          w_asm_nx   = w_asm_shift;
          w_cnt_nx   = CNT_W'(1);
          w_to_nx    = {TO_W{1'b0}};
          w_state_nx = S_RECV;
`ifdef HEADER_LOADER_CHECKSUM_EN
          w_xor_nx   = i_rx_byte;
`endif
        end else begin
          w_to_nx = {TO_W{1'b0}};
        end
      end
      S_RECV: begin
        if (i_rx_valid) begin
          w_asm_nx = w_asm_shift;
          w_to_nx  = {TO_W{1'b0}};
`ifdef HEADER_LOADER_CHECKSUM_EN
          w_xor_nx = r_xor ^ i_rx_byte;
`endif
          if (r_cnt == CNT_LAST) begin
`ifdef HEADER_LOADER_CHECKSUM_EN
            // The header is complete, but it is held back until the checksum byte arrives.
            w_cnt_nx   = CNT_W'(HEADER_BYTES);
            w_state_nx = S_CHECK;
`else
            w_header_nx = w_asm_shift;
            w_valid_nx  = 1'b1;
            w_cnt_nx    = {CNT_W{1'b0}};
            w_state_nx  = S_HOLD;
`endif
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end else if (w_to_expired) begin
          w_cnt_nx   = {CNT_W{1'b0}};
          w_to_nx    = {TO_W{1'b0}};
          w_state_nx = S_IDLE;
        end else begin
          w_to_nx = r_to + TO_W'(1);
        end
      end
`ifdef HEADER_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (i_rx_valid) begin
          w_cnt_nx = {CNT_W{1'b0}};
          w_to_nx  = {TO_W{1'b0}};
          if (i_rx_byte == r_xor) begin
            w_header_nx = r_asm;
            w_valid_nx  = 1'b1;
            w_state_nx  = S_HOLD;
          end else begin
            w_cksum_nx = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else if (w_to_expired) begin
          w_cnt_nx   = {CNT_W{1'b0}};
          w_to_nx    = {TO_W{1'b0}};
          w_state_nx = S_IDLE;
        end else begin
          w_to_nx = r_to + TO_W'(1);
        end
      end
`endif
      S_HOLD: begin
        // A byte that arrives while a header is held is dropped and flagged. This
        // still applies in the same cycle as the ack.
        if (i_rx_valid) begin
          w_overrun_nx = 1'b1;
        end else begin
          w_overrun_nx = r_overrun;
        end
        if (i_header_ack) begin
          w_valid_nx = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_valid_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_valid_nx = 1'b0;
        w_cnt_nx   = {CNT_W{1'b0}};
        w_to_nx    = {TO_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_asm     <= {HDR_W{1'b0}};
      r_header  <= {HDR_W{1'b0}};
      r_valid   <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
      r_to      <= {TO_W{1'b0}};
      r_overrun <= 1'b0;
`ifdef HEADER_LOADER_CHECKSUM_EN
      r_xor     <= 8'h00;
      r_cksum   <= 1'b0;
`endif
    end else begin
      r_asm     <= w_asm_nx;
      r_header  <= w_header_nx;
      r_valid   <= w_valid_nx;
      r_cnt     <= w_cnt_nx;
      r_to      <= w_to_nx;
      r_overrun <= w_overrun_nx;
`ifdef HEADER_LOADER_CHECKSUM_EN
      r_xor     <= w_xor_nx;
      r_cksum   <= w_cksum_nx;
`endif
    end
  end

  assign o_header_data  = r_header;
  assign o_header_valid = r_valid;
  assign o_byte_count   = r_cnt;
  assign o_overrun      = r_overrun;
`ifdef HEADER_LOADER_CHECKSUM_EN
  assign o_cksum_err    = r_cksum;
`else
  assign o_cksum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_header_loader.sv
// -----------------------------------------------------------------------------
// tb_header_loader
//   Directed testbench for header_loader. It uses 80-byte headers and a short
//   timeout so the bench stays small. It follows HEADER_LOADER_CHECKSUM_EN and
//   appends the checksum byte when that macro is defined.
// -----------------------------------------------------------------------------
module tb_header_loader;

  localparam int HB  = 80;
  localparam int TO  = 200;
  localparam int CW  = 7;
  localparam int HW  = 8 * HB;

  logic          i_clock;
  logic          i_reset;
  logic [7:0]    i_rx_byte;
  logic          i_rx_valid;
  logic          i_header_ack;
  logic [HW-1:0] o_header_data;
  logic          o_header_valid;
  logic [CW-1:0] o_byte_count;
  logic          o_overrun;
  logic          o_cksum_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]    fr [0:HB-1];
  logic [HW-1:0] exp_hdr;
  logic [HW-1:0] prev_hdr;
  logic [7:0]    tmp_b;

  header_loader #(
    .HEADER_BYTES  (HB),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_rx_byte     (i_rx_byte),
    .i_rx_valid    (i_rx_valid),
    .i_header_ack  (i_header_ack),
    .o_header_data (o_header_data),
    .o_header_valid(o_header_valid),
    .o_byte_count  (o_byte_count),
    .o_overrun     (o_overrun),
    .o_cksum_err   (o_cksum_err)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven and outputs are sampled.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  function automatic logic [HW-1:0] build_hdr();
    logic [HW-1:0] e;
    e = {HW{1'b0}};
    for (int i = 0; i < HB; i++) e[HW-1-8*i -: 8] = fr[i];
    return e;
  endfunction

  function automatic logic [7:0] frame_xor();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < HB; i++) x = x ^ fr[i];
    return x;
  endfunction

  // Send fr[] with the given strobe spacing; on return the header should be valid.
  task automatic send_frame(input int gap, input bit chk_cnt);
    for (int i = 0; i < HB; i++) begin
      send(fr[i]);
      if (chk_cnt && i < HB - 1) check($sformatf("cnt_b%0d", i + 1), o_byte_count, HW'(i + 1));
      if (i == HB - 2) check("valid_before_last", o_header_valid, 1'b0);
      if (i < HB - 1) idle(gap - 1);
    end
`ifdef HEADER_LOADER_CHECKSUM_EN
    check("cnt_in_check", o_byte_count, HW'(HB));
    check("valid_in_check", o_header_valid, 1'b0);
    send(frame_xor());
`endif
  endtask

  task automatic do_ack();
    i_header_ack = 1'b1;
    tick();
    i_header_ack = 1'b0;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_rx_byte    = 8'h00;
    i_rx_valid   = 1'b0;
    i_header_ack = 1'b0;
    idle(2);
    check("rst_hdr",   o_header_data,  {HW{1'b0}});
    check("rst_valid", o_header_valid, 1'b0);
    check("rst_cnt",   o_byte_count,   {HW{1'b0}});
    check("rst_ovr",   o_overrun,      1'b0);
    check("rst_ckerr", o_cksum_err,    1'b0);
    i_reset = 1'b0;
    idle(2);

    // Incrementing bytes, one strobe every 10 clocks.
    for (int i = 0; i < HB; i++) fr[i] = 8'(i);
    exp_hdr = build_hdr();
    send_frame(10, 1'b0);
    check("t1_valid", o_header_valid, 1'b1);
    check("t1_hdr", o_header_data, exp_hdr);
    check("t1_top", o_header_data[HW-1 -: 8], 8'h00);
    check("t1_low", o_header_data[7:0], 8'h4F);
    check("t1_cnt0", o_byte_count, {HW{1'b0}});
    idle(3);
    check("t1_hold", o_header_valid, 1'b1);
    do_ack();
    check("t1_ack_valid", o_header_valid, 1'b0);
    check("t1_retain", o_header_data, exp_hdr);
    check("t1_ckerr", o_cksum_err, 1'b0);

    // The timeout fires on exactly the TO-th idle clock after the last byte.
    for (int i = 0; i < 30; i++) send(8'h5A);
    check("t2_cnt30", o_byte_count, HW'(30));
    i_header_ack = 1'b1;
    tick();
    i_header_ack = 1'b0;
    check("t2_ack_ignored", o_byte_count, HW'(30));
    idle(TO - 2);
    check("t2_before_to", o_byte_count, HW'(30));
    tick();
    check("t2_after_to", o_byte_count, {HW{1'b0}});
    check("t2_no_valid", o_header_valid, 1'b0);
    check("t2_hdr_keep", o_header_data, exp_hdr);
    for (int i = 0; i < HB; i++) fr[i] = 8'hA5;
    exp_hdr = build_hdr();
    send_frame(2, 1'b0);
    check("t2_valid", o_header_valid, 1'b1);
    check("t2_hdr", o_header_data, exp_hdr);
    do_ack();

    // Overrun while a header is held, then ack together with a strobe.
    for (int i = 0; i < HB; i++) fr[i] = 8'(3 * i + 7);
    exp_hdr = build_hdr();
    send_frame(1, 1'b0);
    check("t3_valid", o_header_valid, 1'b1);
    send(8'h77);
    check("t3_ovr", o_overrun, 1'b1);
    check("t3_hdr_same", o_header_data, exp_hdr);
    check("t3_still_valid", o_header_valid, 1'b1);
    i_header_ack = 1'b1;
    send(8'h66);
    i_header_ack = 1'b0;
    check("t3_ack_valid", o_header_valid, 1'b0);
    check("t3_ovr_sticky", o_overrun, 1'b1);
    check("t3_cnt0", o_byte_count, {HW{1'b0}});
    send(8'h11);
    check("t3_idle_restart", o_byte_count, HW'(1));

    // Asynchronous reset during a partial frame.
    for (int i = 1; i < 40; i++) send(8'h22);
    check("t4_cnt40", o_byte_count, HW'(40));
    #2 i_reset = 1'b1;
    #1;
    check("t4_rst_hdr", o_header_data, {HW{1'b0}});
    check("t4_rst_cnt", o_byte_count, {HW{1'b0}});
    check("t4_rst_ovr", o_overrun, 1'b0);
    check("t4_rst_valid", o_header_valid, 1'b0);
    #1 i_reset = 1'b0;
    tick();
    for (int i = 0; i < HB; i++) fr[i] = 8'(8'hFF - i);
    exp_hdr = build_hdr();
    send_frame(1, 1'b1);
    check("t4_valid", o_header_valid, 1'b1);
    check("t4_hdr", o_header_data, exp_hdr);
    check("t4_ovr_clear", o_overrun, 1'b0);
    do_ack();
    check("t4_ack_valid", o_header_valid, 1'b0);

`ifdef HEADER_LOADER_CHECKSUM_EN
    // A good checksum loads the header, and a bad checksum is rejected.
    for (int i = 0; i < HB; i++) fr[i] = 8'h01;
    exp_hdr = build_hdr();
    for (int i = 0; i < HB; i++) send(fr[i]);
    send(8'h00);
    check("t5_good_valid", o_header_valid, 1'b1);
    check("t5_good_hdr", o_header_data, exp_hdr);
    check("t5_good_ckerr", o_cksum_err, 1'b0);
    do_ack();
    prev_hdr = exp_hdr;
    for (int i = 0; i < HB; i++) send(8'h01);
    send(8'h01);
    check("t5_bad_ckerr", o_cksum_err, 1'b1);
    check("t5_bad_valid", o_header_valid, 1'b0);
    check("t5_bad_cnt", o_byte_count, {HW{1'b0}});
    tick();
    check("t5_ckerr_pulse", o_cksum_err, 1'b0);
    check("t5_bad_hdr_keep", o_header_data, prev_hdr);
    check("t5_bad_no_valid", o_header_valid, 1'b0);
`else
    check("t5_ckerr_tied", o_cksum_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
